// File: rtl/clk_mon_pkg.sv
// clk_mon_pkg: shared state encoding and default expectations for the divided-clock monitor.
package clk_mon_pkg;
    typedef enum logic {ST_IDLE, ST_MEASURE} state_t;
    localparam int DEF_EXP_PERIOD = 4;
    localparam int DEF_EXP_HIGH   = 2;
    localparam int DEF_LOCK_CNT   = 4;
    localparam int DEF_TIMEOUT    = 64;
endpackage

// File: rtl/clk_div_monitor_if.sv
// clk_div_monitor_if: sampled divided clock in, period/high measurements and lock status out.
interface clk_div_monitor_if #(parameter int CNT_W = 8);
    logic             clk_div_in;
    logic             fault_clr;
    logic [CNT_W-1:0] period_o;
    logic [CNT_W-1:0] high_o;
    logic             meas_valid;
    logic             locked;
    logic             fault;
    modport master(output clk_div_in, fault_clr, input period_o, high_o, meas_valid, locked, fault);
    modport slave(input clk_div_in, fault_clr, output period_o, high_o, meas_valid, locked, fault);
endinterface

// File: rtl/edge_detect.sv
// edge_detect: registers the previous sample of a level and flags its rising/falling transitions.
module edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_rise,
    output logic o_fall
);
    logic r_prev;
    always_ff @(posedge clk)
        r_prev <= rst_n ? i_d : 1'b0;
    assign o_rise = i_d & ~r_prev;
    assign o_fall = ~i_d & r_prev;
endmodule

// File: rtl/clk_div_monitor.sv
// clk_div_monitor: measures period/high time of a synchronously divided clock and
// reports lock after repeated matches, with a sticky fault on loss of lock or timeout.
module clk_div_monitor
    import clk_mon_pkg::*;
#(
    parameter int CNT_W      = 8,
    parameter int EXP_PERIOD = DEF_EXP_PERIOD,
    parameter int EXP_HIGH   = DEF_EXP_HIGH,
    parameter int LOCK_CNT   = DEF_LOCK_CNT,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input logic clk,
    input logic rst_n,
    clk_div_monitor_if.slave mon
);
    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    state_t r_state, w_state_nxt;
    logic w_rise, w_fall, w_meas, w_timeout, w_match;
    logic [CNT_W-1:0] r_cnt, r_hcnt, r_period, r_high;
    logic [MW-1:0] r_match_cnt, w_match_nxt;
    logic r_meas_valid, r_locked, r_fault;

    edge_detect u_edge (.clk(clk), .rst_n(rst_n), .i_d(mon.clk_div_in), .o_rise(w_rise), .o_fall(w_fall));

    always_comb assert (!(w_rise && w_fall));

    always_ff @(posedge clk)
        r_state <= rst_n ? w_state_nxt : ST_IDLE;

    always_comb
        w_state_nxt = (r_state == ST_IDLE) ? (w_rise ? ST_MEASURE : ST_IDLE)
                                           : (w_timeout ? ST_IDLE : ST_MEASURE);

    always_comb begin
        w_meas      = (r_state == ST_MEASURE) && w_rise;
        w_timeout   = (r_state == ST_MEASURE) && !w_rise && r_cnt == CNT_W'(TIMEOUT);
        w_match     = r_cnt == CNT_W'(EXP_PERIOD) && r_hcnt == CNT_W'(EXP_HIGH);
        w_match_nxt = (r_match_cnt == MW'(LOCK_CNT)) ? r_match_cnt : r_match_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_hcnt <= '0;
        end else begin
            r_cnt  <= w_rise ? CNT_W'(1) : r_cnt + CNT_W'(r_cnt != CNT_MAX);
            r_hcnt <= w_rise ? CNT_W'(1) : r_hcnt + CNT_W'(mon.clk_div_in && r_hcnt != CNT_MAX);
        end
    end

    // A mismatch only counts as a fault once lock had been established.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_period     <= '0;
            r_high       <= '0;
            r_meas_valid <= 1'b0;
            r_match_cnt  <= '0;
            r_locked     <= 1'b0;
            r_fault      <= 1'b0;
        end else begin
            r_meas_valid <= w_meas;
            if (w_meas) begin
                r_period <= r_cnt;
                r_high   <= r_hcnt;
            end
            if (w_timeout || (w_meas && !w_match)) begin
                r_match_cnt <= '0;
                r_locked    <= 1'b0;
            end else if (w_meas) begin
                r_match_cnt <= w_match_nxt;
                r_locked    <= w_match_nxt == MW'(LOCK_CNT);
            end
            r_fault <= w_timeout || (w_meas && !w_match && r_locked) || (r_fault && !mon.fault_clr);
        end
    end

    assign mon.period_o   = r_period;
    assign mon.high_o     = r_high;
    assign mon.meas_valid = r_meas_valid;
    assign mon.locked     = r_locked;
    assign mon.fault      = r_fault;
endmodule

// File: tb/tb_clk_div_monitor.sv
// tb_clk_div_monitor: directed waveforms with hand-computed measurements, lock and fault results.
module tb_clk_div_monitor;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_total = 0;
    int n_bad = 0;

    clk_div_monitor_if #(.CNT_W(8)) mon ();
    clk_div_monitor dut (.clk(clk), .rst_n(rst_n), .mon(mon));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input logic d, input logic clr = 1'b0);
        mon.clk_div_in = d;
        mon.fault_clr  = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic mv, input int p, input int h,
                           input logic lk, input logic ft);
        chk({tag, "_mv"}, mon.meas_valid, mv);
        chk({tag, "_per"}, mon.period_o, p);
        chk({tag, "_high"}, mon.high_o, h);
        chk({tag, "_lock"}, mon.locked, lk);
        chk({tag, "_fault"}, mon.fault, ft);
    endtask

    // remaining 1,0,0 of a good divide-by-4 period after its rising sample
    task automatic tail();
        step(1'b1);
        chk("mv_gap", mon.meas_valid, 1'b0);
        step(1'b0);
        step(1'b0);
    endtask

    initial begin
        mon.clk_div_in = 1'b0;
        mon.fault_clr  = 1'b0;
        step(1'b0);
        step(1'b0);
        chk_out("reset", 0, 0, 0, 0, 0);
        rst_n = 1'b1;

        // divide-by-4: first partial period is not reported
        step(1'b1);
        chk("t1_first_rise", mon.meas_valid, 1'b0);
        tail();
        for (int k = 1; k <= 4; k++) begin
            step(1'b1);
            chk_out($sformatf("t1_m%0d", k), 1, 4, 2, k == 4, 0);
            tail();
        end

        // stretched period while locked
        step(1'b1);
        chk_out("t2_pre", 1, 4, 2, 1, 0);
        step(1'b1);
        step(1'b0);
        step(1'b0);
        step(1'b0);
        step(1'b1);
        chk_out("t2_stretch", 1, 5, 2, 0, 1);
        tail();
        for (int k = 1; k <= 4; k++) begin
            step(1'b1);
            chk_out($sformatf("t2_relock%0d", k), 1, 4, 2, k == 4, 1);
            tail();
        end

        // clear coinciding with a new mismatch: set wins
        step(1'b0);
        step(1'b1, 1'b1);
        chk_out("t4_setwins", 1, 5, 2, 0, 1);
        tail();
        step(1'b1, 1'b1);
        chk_out("t4_clear", 1, 4, 2, 0, 0);
        tail();
        for (int k = 2; k <= 4; k++) begin
            step(1'b1);
            chk_out($sformatf("t4_lock%0d", k), 1, 4, 2, k == 4, 0);
            tail();
        end

        // stuck low: timeout on the 64th edge after the last rise
        for (int i = 0; i < 60; i++) step(1'b0);
        chk("t3_pre_fault", mon.fault, 1'b0);
        chk("t3_pre_lock", mon.locked, 1'b1);
        step(1'b0);
        chk("t3_fault", mon.fault, 1'b1);
        chk("t3_unlock", mon.locked, 1'b0);
        step(1'b1);
        chk("t3_restart_mv", mon.meas_valid, 1'b0);
        tail();
        step(1'b1);
        chk_out("t3_second", 1, 4, 2, 0, 1);
        tail();
        for (int k = 2; k <= 4; k++) begin
            step(1'b1, k == 2);
            chk_out($sformatf("t3_lock%0d", k), 1, 4, 2, k == 4, 0);
            tail();
        end

        // reset mid-period while locked
        step(1'b1);
        chk("t6_locked", mon.locked, 1'b1);
        rst_n = 1'b0;
        step(1'b1);
        chk_out("t6_reset", 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        step(1'b1);
        chk("t6_first_rise", mon.meas_valid, 1'b0);
        step(1'b0);
        step(1'b0);
        step(1'b1);
        chk_out("t6_meas", 1, 3, 1, 0, 0);

        // duty error: period 4, high 3
        step(1'b1);
        step(1'b1);
        step(1'b0);
        for (int k = 1; k <= 5; k++) begin
            step(1'b1);
            chk_out($sformatf("t5_m%0d", k), 1, 4, 3, 0, 0);
            step(1'b1);
            step(1'b1);
            step(1'b0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
